odo_rosc_meas_ctrl: RTL

- Measurement sequencer for an odometer aging-sensor pair: one stressed ring oscillator and one unstressed reference ring oscillator (NAND delay chains).
- On each request, enables the reference ROSC, then the stressed ROSC, one at a time, and counts edges of each over a programmable window of CLK cycles.
- Reports both counts and their signed difference to the readout logic over a valid/ready handshake.

---
 rtl/odo_rosc_meas_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/odo_rosc_meas_ctrl.sv
// Odometer ring-oscillator measurement sequencer.
// Runs the reference ROSC and then the stressed ROSC, one at a time. Each one
// settles first and then has its rising edges counted over a programmable
// window. Both counts and their signed difference are handed to readout over
// a valid/ready handshake.

// Per-oscillator front end: 2-FF synchronizer, previous-value flop, rise detect.
module odo_rosc_edge (
  input  logic clk,
  input  logic rst,
  input  logic osc,
  output logic rise
);
  logic [1:0] sync;
  logic       prev;

  // Synchronize the asynchronous oscillator and keep one cycle of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], osc};
      prev <= sync[1];
    end
  end

  assign rise = sync[1] & ~prev;
endmodule

module odo_rosc_meas_ctrl #(
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             osc_ref,
  input  logic             osc_str,
  output logic             en_ref,
  output logic             en_str,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] cnt_ref,
  output logic [CNT_W-1:0] cnt_str,
  output logic [CNT_W:0]   diff,
  output logic             sat
);
  localparam int NUM_LANES = 2;  // lane 0 = reference, lane 1 = stressed
  localparam int SET_W     = $clog2(SETTLE) + 1;
  localparam int TMR_W     = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TMR_W-1:0] SET_LD = TMR_W'(SETTLE - 1);

  typedef enum logic [2:0] {IDLE, SET_R, CNT_R, SET_S, CNT_S, REPORT} state_t;

  state_t                 state;
  logic [WIN_W-1:0]       win;
  logic [TMR_W-1:0]       tmr;
  logic [NUM_LANES-1:0]   osc;
  logic [NUM_LANES-1:0]   rise;
  logic [CNT_W-1:0]       ref_nxt, str_nxt;
  logic [TMR_W-1:0]       win_ld;

  assign osc    = {osc_str, osc_ref};
  assign win_ld = TMR_W'(win - 1'b1);

  // Both synchronizers run continuously, whatever the sequencer state.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    odo_rosc_edge u_edge (
      .clk  (clk),
      .rst  (rst),
      .osc  (osc[g]),
      .rise (rise[g])
    );
  end

  // Saturating next counts. They are used only inside the matching count
  // window, and the stressed one also feeds DIFF on entry to REPORT so that
  // an edge seen in the final window cycle is included.
  always_comb begin
    ref_nxt = cnt_ref;
    str_nxt = cnt_str;
    if (rise[0] && !(&cnt_ref)) ref_nxt = cnt_ref + 1'b1;
    if (rise[1] && !(&cnt_str)) str_nxt = cnt_str + 1'b1;
  end

  // Sequencer. The enables, busy and valid are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      win     <= '0;
      tmr     <= '0;
      en_ref  <= 1'b0;
      en_str  <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      cnt_ref <= '0;
      cnt_str <= '0;
      diff    <= '0;
      sat     <= 1'b0;
    end else if (abort) begin
      // Partial counts are kept. A pending result is dropped.
      state  <= IDLE;
      en_ref <= 1'b0;
      en_str <= 1'b0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && win_len != '0) begin
            win     <= win_len;
            cnt_ref <= '0;
            cnt_str <= '0;
            sat     <= 1'b0;
            tmr     <= SET_LD;
            state   <= SET_R;
            en_ref  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SET_R: begin
          if (tmr == '0) begin
            tmr   <= win_ld;
            state <= CNT_R;
          end else tmr <= tmr - 1'b1;
        end
        CNT_R: begin
          cnt_ref <= ref_nxt;
          if (rise[0] && (&cnt_ref)) sat <= 1'b1;
          if (tmr == '0) begin
            tmr    <= SET_LD;
            state  <= SET_S;
            en_ref <= 1'b0;
            en_str <= 1'b1;
          end else tmr <= tmr - 1'b1;
        end
        SET_S: begin
          if (tmr == '0) begin
            tmr   <= win_ld;
            state <= CNT_S;
          end else tmr <= tmr - 1'b1;
        end
        CNT_S: begin
          cnt_str <= str_nxt;
          if (rise[1] && (&cnt_str)) sat <= 1'b1;
          if (tmr == '0) begin
            state  <= REPORT;
            en_str <= 1'b0;
            valid  <= 1'b1;
            diff   <= {1'b0, str_nxt} - {1'b0, cnt_ref};
          end else tmr <= tmr - 1'b1;
        end
        REPORT: begin
          if (ready) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          en_ref <= 1'b0;
          en_str <= 1'b0;
          busy   <= 1'b0;
          valid  <= 1'b0;
        end
      endcase
    end
  end
endmodule
